spi_master_driver: RTL and testbench
====================================

# spi_master_driver

Synchronous SPI master that sits directly upstream of the SPI slave and generates its SS_n/MOSI frames from parallel command requests. Each request carries one 10-bit slave frame (2-bit opcode + 8-bit payload); the block frames it, serialises it MSB first and, for read-data frames, collects the 8-bit reply from MISO. It replaces hand-driven serial stimulus as the system-level front end of the SPI slave + single-port RAM subsystem.

## Interface
- TURN_CYCLES, 2: cycles between the last MOSI bit of a read-data frame and the first MISO sample (≥1).
- IDLE_GAP, 1: cycles SS_n is held high after every frame before the next request is accepted (≥1).
- clk  input  1  sole clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request (high only in IDLE).
- req_frame  input  10  [9:8] opcode (00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA), [7:0] payload.
- rsp_valid  output  1  one-cycle pulse: rsp_data holds a read reply.
- rsp_data  output  8  byte captured from MISO.
- err  output  1  one-cycle pulse: request rejected (see Configuration).
- busy  output  1  high whenever state != IDLE.
- SS_n  output  1  slave select, active-low.
- MOSI  output  1  serial data to slave.
- MISO  input  1  serial data from slave.

## Operation
- States: IDLE, SEL, SHIFT, TURN, RECV, GAP.
- IDLE: req_ready=1. On req_valid, latch req_frame, go SEL.
- SEL (1 cycle): SS_n=0, MOSI=frame[9] (slave's write/read select bit). Go SHIFT.
- SHIFT (10 cycles, 4-bit counter 9 down to 0): SS_n=0, MOSI=frame[cnt]. After bit 0: opcode 11 -> TURN, else -> GAP.
- TURN (TURN_CYCLES cycles): SS_n=0, MOSI=0. Go RECV.
- RECV (8 cycles): SS_n=0, MOSI=0; sample MISO each posedge, shift in MSB first. After 8th sample: load rsp_data, pulse rsp_valid, go GAP.
- GAP (IDLE_GAP cycles): SS_n=1, MOSI=0. Go IDLE.
- Reset values (immediate, asynchronous): state IDLE, SS_n=1, MOSI=0, rsp_valid=0, rsp_data=8'h00, err=0, busy=0, req_ready=1 once released.
- Reset mid-frame: frame abandoned, no rsp_valid, SS_n returns high at once; slave sees aborted frame.
- rsp_data holds last reply until next read completes or reset.
- req_valid outside IDLE ignored; requester must hold req_valid until req_ready.

## Timing
- All outputs registered; no combinational input-to-output path except req_ready (decoded from state register).
- Request accepted at edge k: SS_n low from k to the edge ending SHIFT/RECV.
- Write/RD_ADDR frame: SS_n low 11 cycles (1 SEL + 10 SHIFT), then IDLE_GAP high; next accept earliest at k+11+IDLE_GAP.
- RD_DATA frame: SS_n low 11+TURN_CYCLES+8 cycles; rsp_valid at edge k+19+TURN_CYCLES, coincident with SS_n rising.
- Back-to-back requests: throughput one frame per (frame length + IDLE_GAP) cycles.

## Configuration
- SPI_MASTER_CMD_CHECK_EN defined: block tracks whether an RD_ADDR frame has completed since reset or the last RD_DATA. An RD_DATA request without it is accepted (req_ready handshake completes), not sent (SS_n stays high), err pulses one cycle after acceptance, state stays IDLE. WR_ADDR/WR_DATA never affect the flag.
- Not defined: no tracking, all requests sent, err tied 0.

## Structure
- shared_pkg: spi_master_state_e enum, opcode constants (WR_ADDR, WR_DATA, RD_ADDR, RD_DATA), default TURN_CYCLES/IDLE_GAP parameters.
- One sub-module: spi_master_shifter — 10-bit load/shift-out register for MOSI plus 8-bit shift-in register for MISO, controlled by load/shift/capture strobes from the FSM.

## Test plan
- Reset with req_valid=1, frame 10'h0A5 -> SS_n=1, MOSI=0, rsp_valid=0, rsp_data=0, req_ready=1 after release.
- WR_ADDR 10'h012 -> SS_n low 11 cycles, MOSI sequence 0,0,0,0,0,0,1,0,0,1,0, then SS_n high 1 cycle, req_ready back.
- RD_ADDR 10'h234 then RD_DATA 10'h300 with slave returning 8'hC3 -> rsp_valid pulse at accept+21 (TURN_CYCLES=2), rsp_data=8'hC3.
- Two queued WR_DATA requests held valid -> second SEL starts exactly IDLE_GAP cycles after first SS_n rise.
- rst_n low during 5th SHIFT bit of RD_DATA -> SS_n high same cycle, no rsp_valid, next request handled normally.
- With SPI_MASTER_CMD_CHECK_EN: RD_DATA straight after reset -> err pulse, SS_n never low; without macro -> frame sent, err=0.

Source files
------------

// File: rtl/spi_master_driver_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_master_driver_pkg                                                      |
// | Shared states, opcodes and default timing for the SPI master driver.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package spi_master_driver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEL   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TURN  = 3'd3,
        ST_RECV  = 3'd4,
        ST_GAP   = 3'd5
    } spi_master_state_e;

    localparam logic [1:0] C_OP_WR_ADDR = 2'b00;
    localparam logic [1:0] C_OP_WR_DATA = 2'b01;
    localparam logic [1:0] C_OP_RD_ADDR = 2'b10;
    localparam logic [1:0] C_OP_RD_DATA = 2'b11;

    localparam int DEF_TURN_CYCLES = 2;
    localparam int DEF_IDLE_GAP    = 1;

    function automatic logic [1:0] frame_op(input logic [9:0] frame);
        return frame[9:8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_master_driver_if                                                       |
// | Request/response handshake plus SPI pins; master = driver, slave = peer.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface spi_master_driver_if;
    logic       req_valid;
    logic       req_ready;
    logic [9:0] req_frame;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       err;
    logic       busy;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    modport master (
        input  req_valid, req_frame, MISO,
        output req_ready, rsp_valid, rsp_data, err, busy, SS_n, MOSI
    );

    modport slave (
        output req_valid, req_frame, MISO,
        input  req_ready, rsp_valid, rsp_data, err, busy, SS_n, MOSI
    );
endinterface
`default_nettype wire

// File: rtl/spi_master_driver_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_master_driver_shifter                                                  |
// | 10-bit MSB-first transmit register and 8-bit MSB-first receive register.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module spi_master_driver_shifter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [9:0] i_frame,
    input  logic       i_shift,
    input  logic       i_capture,
    input  logic       i_miso,
    output logic       o_tx_msb,
    output logic [7:0] o_rx
);

    logic [9:0] r_tx;
    logic [7:0] r_rx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx <= 10'h000;
            r_rx <= 8'h00;
        end else begin
            if (i_load) begin
                r_tx <= i_frame;
            end else if (i_shift) begin
                r_tx <= {r_tx[8:0], 1'b0};
            end
            if (i_capture) begin
                r_rx <= {r_rx[6:0], i_miso};
            end
        end
    end

    assign o_tx_msb = r_tx[9];
    assign o_rx     = r_rx;

endmodule
`default_nettype wire

// File: rtl/spi_master_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_master_driver                                                          |
// | Frames 10-bit slave commands onto SS_n/MOSI and collects RD_DATA replies.  |
// | Optional: SPI_MASTER_CMD_CHECK_EN rejects RD_DATA without a prior RD_ADDR. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module spi_master_driver
    import spi_master_driver_pkg::*;
#(
    parameter int TURN_CYCLES = DEF_TURN_CYCLES,
    parameter int IDLE_GAP    = DEF_IDLE_GAP
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_master_driver_if.master bus
);

    localparam int DLY_MAX = (TURN_CYCLES > IDLE_GAP) ? TURN_CYCLES : IDLE_GAP;
    localparam int DLY_W   = (DLY_MAX < 2) ? 1 : $clog2(DLY_MAX);
    localparam logic [DLY_W-1:0] C_TURN_LOAD = DLY_W'(TURN_CYCLES - 1);
    // The IDLE cycle before the next accept is itself the last SS_n-high cycle.
    localparam logic [DLY_W-1:0] C_GAP_LOAD  = DLY_W'((IDLE_GAP > 1) ? (IDLE_GAP - 2) : 0);

    spi_master_state_e r_state;
    logic [1:0]        r_op;
    logic [3:0]        r_bit_cnt;
    logic [DLY_W-1:0]  r_dly_cnt;
    logic              r_ss_n;
    logic              r_mosi;
    logic              r_busy;
    logic              r_rsp_valid;
    logic [7:0]        r_rsp_data;

    logic              w_accept;
    logic              w_reject;
    logic              w_load;
    logic              w_shift;
    logic              w_capture;
    logic              w_tx_msb;
    logic [7:0]        w_rx;

    assign w_accept  = (r_state == ST_IDLE) && bus.req_valid;
    assign w_load    = w_accept && !w_reject;
    assign w_shift   = (r_state == ST_SEL) || (r_state == ST_SHIFT);
    assign w_capture = (r_state == ST_RECV);

    spi_master_driver_shifter u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_frame   (bus.req_frame),
        .i_shift   (w_shift),
        .i_capture (w_capture),
        .i_miso    (bus.MISO),
        .o_tx_msb  (w_tx_msb),
        .o_rx      (w_rx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= 2'b00;
            r_bit_cnt   <= 4'd0;
            r_dly_cnt   <= '0;
            r_ss_n      <= 1'b1;
            r_mosi      <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'h00;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_state <= ST_SEL;
                        r_op    <= frame_op(bus.req_frame);
                        r_ss_n  <= 1'b0;
                        r_mosi  <= bus.req_frame[9];
                        r_busy  <= 1'b1;
                    end
                end
                ST_SEL: begin
                    r_state   <= ST_SHIFT;
                    r_bit_cnt <= 4'd9;
                    r_mosi    <= w_tx_msb;
                end
                ST_SHIFT: begin
                    if (r_bit_cnt != 4'd0) begin
                        r_bit_cnt <= r_bit_cnt - 4'd1;
                        r_mosi    <= w_tx_msb;
                    end else if (r_op == C_OP_RD_DATA) begin
                        r_state   <= ST_TURN;
                        r_dly_cnt <= C_TURN_LOAD;
                        r_mosi    <= 1'b0;
                    end else begin
                        r_state   <= (IDLE_GAP > 1) ? ST_GAP : ST_IDLE;
                        r_dly_cnt <= C_GAP_LOAD;
                        r_busy    <= (IDLE_GAP > 1);
                        r_ss_n    <= 1'b1;
                        r_mosi    <= 1'b0;
                    end
                end
                ST_TURN: begin
                    if (r_dly_cnt == '0) begin
                        r_state   <= ST_RECV;
                        r_bit_cnt <= 4'd7;
                    end else begin
                        r_dly_cnt <= r_dly_cnt - 1'b1;
                    end
                end
                ST_RECV: begin
                    if (r_bit_cnt != 4'd0) begin
                        r_bit_cnt <= r_bit_cnt - 4'd1;
                    end else begin
                        r_rsp_data  <= {w_rx[6:0], bus.MISO};
                        r_rsp_valid <= 1'b1;
                        r_state     <= (IDLE_GAP > 1) ? ST_GAP : ST_IDLE;
                        r_dly_cnt   <= C_GAP_LOAD;
                        r_busy      <= (IDLE_GAP > 1);
                        r_ss_n      <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_dly_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_dly_cnt <= r_dly_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ss_n  <= 1'b1;
                    r_mosi  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPI_MASTER_CMD_CHECK_EN
    logic r_rd_addr_seen;
    logic r_err;

    assign w_reject = w_accept && (frame_op(bus.req_frame) == C_OP_RD_DATA) && !r_rd_addr_seen;

    // Flag arms when an RD_ADDR frame finishes shifting; a sent RD_DATA consumes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr_seen <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_err <= w_reject;
            if ((r_state == ST_SHIFT) && (r_bit_cnt == 4'd0) && (r_op == C_OP_RD_ADDR)) begin
                r_rd_addr_seen <= 1'b1;
            end else if (w_load && (frame_op(bus.req_frame) == C_OP_RD_DATA)) begin
                r_rd_addr_seen <= 1'b0;
            end
        end
    end

    assign bus.err = r_err;
`else
    assign w_reject = 1'b0;
    assign bus.err  = 1'b0;
`endif

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.busy      = r_busy;
    assign bus.SS_n      = r_ss_n;
    assign bus.MOSI      = r_mosi;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_master_driver                                                       |
// | Table-driven frame checks with a reply scoreboard, plus reset/err cases.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_spi_master_driver;

    localparam int TURN = 2;
    localparam int GAP  = 1;

    typedef struct {
        logic [9:0] frame;
        logic [7:0] reply;
        logic       exp_rsp;
        int         exp_len;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    logic [7:0] last_reply;
    logic [7:0] sb[$];
    vec_t vecs[8];

    spi_master_driver_if bus ();

    spi_master_driver #(
        .TURN_CYCLES (TURN),
        .IDLE_GAP    (GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic run_frame(input vec_t v);
        int   t;
        int   j;
        logic exp_mosi;
        logic [7:0] exp_byte;
        t = 0;
        while (bus.req_ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("accept_ready", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_frame = v.frame;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (v.exp_rsp) sb.push_back(v.reply);
        for (int i = 0; i <= v.exp_len; i++) begin
            if (i == 0)       exp_mosi = v.frame[9];
            else if (i <= 10) exp_mosi = v.frame[10 - i];
            else              exp_mosi = 1'b0;
            chk("ss_n",      {31'd0, bus.SS_n},      {31'd0, (i >= v.exp_len)});
            chk("mosi",      {31'd0, bus.MOSI},      {31'd0, exp_mosi});
            chk("busy",      {31'd0, bus.busy},      {31'd0, (i < v.exp_len + GAP - 1)});
            chk("req_ready", {31'd0, bus.req_ready}, {31'd0, (i >= v.exp_len + GAP - 1)});
            chk("err",       {31'd0, bus.err},       32'd0);
            chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, (i == v.exp_len) && v.exp_rsp});
            if (bus.rsp_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_byte = sb.pop_front();
                    chk("rsp_data", {24'd0, bus.rsp_data}, {24'd0, exp_byte});
                    last_reply = exp_byte;
                end
            end
            j = i - (11 + TURN);
            if (j >= 0 && j < 8) bus.MISO = v.reply[7 - j];
            else                 bus.MISO = 1'b0;
            if (i < v.exp_len) @(negedge clk);
        end
        chk("rsp_hold", {24'd0, bus.rsp_data}, {24'd0, last_reply});
        chk("sb_empty", sb.size(), 32'd0);
    endtask

    initial begin
        int   bad;
        vec_t v;
        n_checks   = 0;
        n_pass     = 0;
        last_reply = 8'h00;

        vecs[0] = '{10'h012, 8'h00, 1'b0, 11};
        vecs[1] = '{10'h234, 8'h00, 1'b0, 11};
        vecs[2] = '{10'h300, 8'hC3, 1'b1, 21};
        vecs[3] = '{10'h1A5, 8'h00, 1'b0, 11};
        vecs[4] = '{10'h15A, 8'h00, 1'b0, 11};
        vecs[5] = '{10'h2FF, 8'h00, 1'b0, 11};
        vecs[6] = '{10'h3FF, 8'h5A, 1'b1, 21};
        vecs[7] = '{10'h210, 8'h00, 1'b0, 11};

        // Reset with a request pending
        rst_n         = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_frame = 10'h0A5;
        bus.MISO      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ss_n",      {31'd0, bus.SS_n},      32'd1);
        chk("rst_mosi",      {31'd0, bus.MOSI},      32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_data",  {24'd0, bus.rsp_data},  32'd0);
        chk("rst_err",       {31'd0, bus.err},       32'd0);
        chk("rst_busy",      {31'd0, bus.busy},      32'd0);
        bus.req_valid = 1'b0;
        rst_n         = 1'b1;
        @(negedge clk);
        chk("rel_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rel_ss_n",  {31'd0, bus.SS_n},      32'd1);

        // RD_DATA straight after reset
`ifdef SPI_MASTER_CMD_CHECK_EN
        bus.req_valid = 1'b1;
        bus.req_frame = 10'h381;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("chk_err_pulse", {31'd0, bus.err},       32'd1);
        chk("chk_ss_n",      {31'd0, bus.SS_n},      32'd1);
        chk("chk_ready",     {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        chk("chk_err_clear", {31'd0, bus.err},       32'd0);
        bad = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.SS_n !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.err !== 1'b0) bad++;
        end
        chk("chk_no_frame", bad, 32'd0);
`else
        v = '{10'h381, 8'h96, 1'b1, 21};
        run_frame(v);
`endif

        for (int k = 0; k < 8; k++) begin
            run_frame(vecs[k]);
        end

        // Reset during the 5th SHIFT bit of an RD_DATA frame
        bus.req_valid = 1'b1;
        bus.req_frame = 10'h3AA;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_ss_low", {31'd0, bus.SS_n}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ss_n",  {31'd0, bus.SS_n},      32'd1);
        chk("mid_rst_mosi",  {31'd0, bus.MOSI},      32'd0);
        chk("mid_rst_busy",  {31'd0, bus.busy},      32'd0);
        chk("mid_rst_rdata", {24'd0, bus.rsp_data},  32'd0);
        repeat (3) @(negedge clk);
        rst_n      = 1'b1;
        last_reply = 8'h00;
        bad = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || bus.SS_n !== 1'b1) bad++;
        end
        chk("abort_quiet", bad, 32'd0);
        v = '{10'h0C3, 8'h00, 1'b0, 11};
        run_frame(v);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
